// File: rtl/doctor_unit.sv
// Doctor control panel: debounces the status/history/change buttons, emits
// one-cycle press strobes while sw is on, and keeps the postop mode flag.
module doctor_unit #(
  parameter int unsigned Nbit = 4,
  parameter int unsigned nMAX = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic status,
  input  logic history,
  input  logic change,
  input  logic sw,
  output logic postop,
  output logic tasto_status,
  output logic tasto_hist,
  output logic tasto_change
);

  localparam int unsigned NCH = 3;
  localparam logic [Nbit-1:0] CNT_LAST = Nbit'(nMAX - 1);

  logic [NCH-1:0]  raw;
  logic [NCH-1:0]  db;
  logic [NCH-1:0]  db_nxt;
  logic [NCH-1:0]  rise;
  logic [Nbit-1:0] cnt     [NCH];
  logic [Nbit-1:0] cnt_nxt [NCH];

  // Channel order: 0 = status, 1 = history, 2 = change
  assign raw = {change, history, status};

  // Debounce: a level is accepted after nMAX consecutive differing samples
  always_comb begin
    db_nxt = db;
    for (int i = 0; i < NCH; i++) begin
      cnt_nxt[i] = '0;
      if (raw[i] != db[i]) begin
        if (cnt[i] == CNT_LAST) begin
          db_nxt[i] = raw[i];
        end else begin
          cnt_nxt[i] = cnt[i] + Nbit'(1);
        end
      end
    end
  end

  assign rise = db_nxt & ~db;

  always_ff @(posedge clk) begin
    if (rst) begin
      db           <= '0;
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
      postop       <= 1'b0;
      tasto_status <= 1'b0;
      tasto_hist   <= 1'b0;
      tasto_change <= 1'b0;
    end else begin
      db           <= db_nxt;
      for (int i = 0; i < NCH; i++) cnt[i] <= cnt_nxt[i];
      tasto_status <= rise[0] & sw;
      tasto_hist   <= rise[1] & sw;
      tasto_change <= rise[2] & sw;
      // Presses accepted while the panel is off are dropped, not replayed
      if (rise[2] && sw) postop <= ~postop;
    end
  end

endmodule

// File: tb/tb_doctor_unit.sv
// Scoreboard bench for doctor_unit: a sample-history reference model predicts
// every cycle's outputs; a monitor compares them as the DUT produces them.
module tb_doctor_unit;

  localparam int unsigned NBIT = 4;
  localparam int unsigned NMAX = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic status = 1'b0, history = 1'b0, change = 1'b0, sw = 1'b0;
  logic postop, tasto_status, tasto_hist, tasto_change;

  doctor_unit #(.Nbit(NBIT), .nMAX(NMAX)) dut (
    .clk(clk), .rst(rst), .status(status), .history(history),
    .change(change), .sw(sw), .postop(postop),
    .tasto_status(tasto_status), .tasto_hist(tasto_hist),
    .tasto_change(tasto_change)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   idx;
    logic postop;
    logic [2:0] strobe;
  } exp_t;

  exp_t expq[$];
  int errors = 0;
  int checks = 0;
  int edge_idx = 0;
  int pulses[3];
  int last_strobe[3];

  // Reference model state: raw samples seen since reset, accepted levels, flag
  logic [2:0] hist[$];
  logic [2:0] lvl_m;
  logic       postop_m;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, edge_idx);
    end
  endtask

  // A button's accepted level flips once its last NMAX samples all disagree with it
  task automatic model_edge(input logic r, input logic [2:0] raw, input logic w,
                            output exp_t e);
    logic [2:0] rise;
    bit all_diff;
    e.idx = edge_idx;
    rise = '0;
    if (r) begin
      hist.delete();
      lvl_m = '0;
      postop_m = 1'b0;
    end else begin
      hist.push_back(raw);
      if (hist.size() > NMAX) void'(hist.pop_front());
      for (int ch = 0; ch < 3; ch++) begin
        all_diff = (hist.size() == NMAX);
        foreach (hist[k]) if (hist[k][ch] == lvl_m[ch]) all_diff = 0;
        if (all_diff) begin
          rise[ch] = ~lvl_m[ch];
          lvl_m[ch] = ~lvl_m[ch];
        end
      end
      if (w && rise[2]) postop_m = ~postop_m;
    end
    e.strobe = w ? rise : 3'b000;
    e.postop = postop_m;
  endtask

  // Drive one cycle of inputs at the falling edge and predict the next edge
  task automatic step(input logic r, input logic s, input logic h,
                      input logic c, input logic w);
    exp_t e;
    @(negedge clk);
    rst = r; status = s; history = h; change = c; sw = w;
    edge_idx++;
    model_edge(r, {c, h, s}, w, e);
    expq.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare the DUT's registered outputs just after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("postop", int'(postop), int'(e.postop));
        check("tasto_status", int'(tasto_status), int'(e.strobe[0]));
        check("tasto_hist", int'(tasto_hist), int'(e.strobe[1]));
        check("tasto_change", int'(tasto_change), int'(e.strobe[2]));
        if (tasto_status === 1'b1) begin pulses[0]++; last_strobe[0] = e.idx; end
        if (tasto_hist   === 1'b1) begin pulses[1]++; last_strobe[1] = e.idx; end
        if (tasto_change === 1'b1) begin pulses[2]++; last_strobe[2] = e.idx; end
      end
    end
  end

  initial begin
    int p0, p1, p2, first;
    logic [2:0] lvl;
    int run[3];
    logic sw_r;
    lvl_m = '0;
    postop_m = 1'b0;
    for (int i = 0; i < 3; i++) begin pulses[i] = 0; last_strobe[i] = -1; end

    // Reset, then idle with the panel on: nothing may strobe
    repeat (3) step(1, 0, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0, 1);
    settle();
    check("idle_no_strobe", pulses[0] + pulses[1] + pulses[2], 0);

    // History held 20 cycles: one strobe, accepted on the NMAX-th sampling edge
    first = edge_idx + 1;
    repeat (20) step(0, 0, 1, 0, 1);
    repeat (15) step(0, 0, 0, 0, 1);
    settle();
    check("hist_once", pulses[1], 1);
    check("hist_latency", last_strobe[1] - first, int'(NMAX) - 1);
    check("hist_other_quiet", pulses[0] + pulses[2], 0);

    // Short status glitch rejected, long press accepted
    p0 = pulses[0];
    repeat (5) step(0, 1, 0, 0, 1);
    repeat (10) step(0, 0, 0, 0, 1);
    settle();
    check("status_glitch", pulses[0] - p0, 0);
    repeat (15) step(0, 1, 0, 0, 1);
    repeat (15) step(0, 0, 0, 0, 1);
    settle();
    check("status_press", pulses[0] - p0, 1);

    // Two change presses toggle postop up then back down
    p2 = pulses[2];
    repeat (2) begin
      repeat (15) step(0, 0, 0, 1, 1);
      repeat (15) step(0, 0, 0, 0, 1);
    end
    settle();
    check("change_twice", pulses[2] - p2, 2);
    check("postop_back_to_0", int'(postop), 0);

    // Press accepted with sw=0 is lost; fresh press after release counts
    p2 = pulses[2];
    repeat (20) step(0, 0, 0, 1, 0);
    repeat (10) step(0, 0, 0, 1, 1);
    settle();
    check("sw_off_lost", pulses[2] - p2, 0);
    check("sw_off_postop", int'(postop), 0);
    repeat (15) step(0, 0, 0, 0, 1);
    repeat (15) step(0, 0, 0, 1, 1);
    repeat (15) step(0, 0, 0, 0, 1);
    settle();
    check("sw_on_press", pulses[2] - p2, 1);
    check("sw_on_postop", int'(postop), 1);

    // Reset mid-debounce clears everything; a full NMAX run is needed afterwards
    p2 = pulses[2];
    repeat (8) step(0, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    first = edge_idx + 1;
    repeat (20) step(0, 0, 0, 1, 1);
    repeat (15) step(0, 0, 0, 0, 1);
    settle();
    check("rst_mid_once", pulses[2] - p2, 1);
    check("rst_mid_latency", last_strobe[2] - first, int'(NMAX) - 1);
    check("rst_mid_postop", int'(postop), 1);

    // Random phase: buttons hold levels for random run lengths
    lvl = '0;
    sw_r = 1'b1;
    for (int i = 0; i < 3; i++) run[i] = 0;
    p1 = 0;
    repeat (4000) begin
      for (int ch = 0; ch < 3; ch++) begin
        if (run[ch] == 0) begin
          lvl[ch] = ~lvl[ch];
          run[ch] = $urandom_range(1, 22);
        end
        run[ch]--;
      end
      if ($urandom_range(0, 49) == 0) sw_r = ~sw_r;
      p1 = ($urandom_range(0, 299) == 0) ? 1 : 0;
      step(p1[0], lvl[0], lvl[1], lvl[2], sw_r);
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drained", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
